// File: rtl/ex_branch_resolve_pkg.sv
// Shared definitions for the EX-stage branch resolver: branch-type codes,
// FSM state encoding, flush counter width and the registered EX/MEM payload.
package ex_branch_resolve_pkg;

  // br_type encoding presented by ID/EX; 3'b111 is reserved and behaves as none.
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_JAL  = 3'b101,
    BR_JALR = 3'b110,
    BR_RSVD = 3'b111
  } br_type_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int unsigned CNT_W = 3;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb_en;
  } payload_t;

endpackage

// File: rtl/ex_branch_resolve_if.sv
// Bundle of the ID/EX input handshake, the EX/MEM output handshake and the
// redirect path to IF.
//   master : upstream/downstream environment (drives inputs, sees results)
//   slave  : ex_branch_resolve itself
interface ex_branch_resolve_if;
  // ID/EX side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] alu_c;
  logic        alu_zero;
  logic        alu_sgn;
  logic [2:0]  br_type;
  logic [4:0]  rd;
  logic        wb_en;
  // EX/MEM side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  // IF redirect
  logic        redir_valid;
  logic [31:0] redir_pc;

  modport master (
    output in_valid, pc, imm, alu_c, alu_zero, alu_sgn, br_type, rd, wb_en,
    output out_ready,
    input  in_ready, out_valid, out_res, out_rd, out_wb_en,
    input  redir_valid, redir_pc
  );

  modport slave (
    input  in_valid, pc, imm, alu_c, alu_zero, alu_sgn, br_type, rd, wb_en,
    input  out_ready,
    output in_ready, out_valid, out_res, out_rd, out_wb_en,
    output redir_valid, redir_pc
  );
endinterface

// File: rtl/ex_branch_resolve_br_cond.sv
// Combinational branch/jump decode.
//   br_type_i  : branch type code
//   pc_i/imm_i : PC and sign-extended offset (branch/JAL target base)
//   alu_hi_i   : ALU result bits [31:1] (JALR target, bit 0 cleared)
//   alu_zero_i : ALU zero flag, alu_sgn_i : ALU sign flag
//   taken_o    : control transfer taken
//   target_o   : redirect target
//   link_o     : JAL/JALR, writes pc+4
//   cond_br_o  : conditional branch, never writes back
module ex_branch_resolve_br_cond
  import ex_branch_resolve_pkg::*;
(
  input  logic [2:0]  br_type_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:1] alu_hi_i,
  input  logic        alu_zero_i,
  input  logic        alu_sgn_i,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic        link_o,
  output logic        cond_br_o
);

  br_type_e bt;
  assign bt = br_type_e'(br_type_i);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    taken_o   = 1'b0;
    link_o    = 1'b0;
    cond_br_o = 1'b0;
    case (bt)
      // Signed compares trust the sign of SUB; overflow is deliberately not corrected.
      BR_BEQ:  begin cond_br_o = 1'b1; taken_o = alu_zero_i;  end
      BR_BNE:  begin cond_br_o = 1'b1; taken_o = !alu_zero_i; end
      BR_BLT:  begin cond_br_o = 1'b1; taken_o = alu_sgn_i;   end
      BR_BGE:  begin cond_br_o = 1'b1; taken_o = !alu_sgn_i;  end
      BR_JAL,
      BR_JALR: begin link_o = 1'b1; taken_o = 1'b1; end
      default: ;
    endcase
  end

  // pc+imm wraps modulo 2^32.
  assign target_o = (bt == BR_JALR) ? {alu_hi_i, 1'b0} : (pc_i + imm_i);

endmodule

// File: rtl/ex_branch_resolve.sv
// EX-stage back end: resolves branches/jumps and registers the EX/MEM
// payload behind a valid/ready slice. A taken transfer pulses a redirect to
// IF and then drops FLUSH_CYCLES worth of accepted wrong-path inputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave view of ex_branch_resolve_if (ID/EX in, EX/MEM out, redirect)
// Parameters: FLUSH_CYCLES (1..7) drop window length, RESET_PC redir_pc reset value.
module ex_branch_resolve
  import ex_branch_resolve_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0
)(
  input  logic             clk,
  input  logic             rst_n,
  ex_branch_resolve_if.slave bus
);

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  payload_t    pay_q, pay_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        in_ready;
  logic        accept;
  logic        taken;
  logic        link;
  logic        cond_br;
  logic [31:0] target;

  ex_branch_resolve_br_cond u_br_cond (
    .br_type_i  (bus.br_type),
    .pc_i       (bus.pc),
    .imm_i      (bus.imm),
    .alu_hi_i   (bus.alu_c[31:1]),
    .alu_zero_i (bus.alu_zero),
    .alu_sgn_i  (bus.alu_sgn),
    .taken_o    (taken),
    .target_o   (target),
    .link_o     (link),
    .cond_br_o  (cond_br)
  );

  // During FLUSH inputs are always swallowed, so the stall back-pressure
  // only applies in RUN.
  assign in_ready = (state_q == ST_FLUSH) || !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    pay_d         = pay_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;

    // Downstream handshake retires the held payload in either state.
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          pay_d.res   = link ? (bus.pc + 32'd4) : bus.alu_c;
          pay_d.rd    = bus.rd;
          pay_d.wb_en = bus.wb_en && !cond_br && (bus.rd != 5'd0);
          // The taken instruction itself still goes to MEM (JAL/JALR link).
          if (taken) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = target;
            state_d       = ST_FLUSH;
            cnt_d         = cnt_t'(FLUSH_CYCLES);
          end
        end
      end
      ST_FLUSH: begin
        // Anything accepted here is wrong-path and simply not captured.
        if (cnt_q <= cnt_t'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      pay_q         <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= RESET_PC;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      pay_q         <= pay_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_res     = pay_q.res;
  assign bus.out_rd      = pay_q.rd;
  assign bus.out_wb_en   = pay_q.wb_en;
  assign bus.redir_valid = redir_valid_q;
  assign bus.redir_pc    = redir_pc_q;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Self-checking bench for ex_branch_resolve: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_ex_branch_resolve;

  localparam int FLUSH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_branch_resolve_if bus();

  ex_branch_resolve #(.FLUSH_CYCLES(FLUSH), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: what the outputs must be after the most recent edge.
  logic        m_ov;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  logic        m_wb;
  logic        m_rv;
  logic [31:0] m_rpc;
  int          m_flush;   // remaining cycles in which accepted inputs are dropped

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_res = '0; m_rd = '0; m_wb = 1'b0;
    m_rv = 1'b0; m_rpc = 32'h0; m_flush = 0;
  endtask

  task automatic compare_outputs();
    check("out_valid",   {31'b0, bus.out_valid},   {31'b0, m_ov});
    check("out_res",     bus.out_res,              m_res);
    check("out_rd",      {27'b0, bus.out_rd},      {27'b0, m_rd});
    check("out_wb_en",   {31'b0, bus.out_wb_en},   {31'b0, m_wb});
    check("redir_valid", {31'b0, bus.redir_valid}, {31'b0, m_rv});
    check("redir_pc",    bus.redir_pc,             m_rpc);
  endtask

  task automatic set_in(input logic v, input logic [2:0] bt, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] c, input logic z,
                        input logic s, input logic [4:0] rd, input logic wb);
    bus.in_valid = v;  bus.br_type = bt; bus.pc = pc; bus.imm = imm;
    bus.alu_c = c;     bus.alu_zero = z; bus.alu_sgn = s;
    bus.rd = rd;       bus.wb_en = wb;
  endtask

  // One clock: check in_ready against the current inputs, advance the model
  // by the rules, then compare registered outputs at the next falling edge.
  task automatic tick();
    logic exp_ready, acc, taken;
    int   bt;
    #1;
    exp_ready = (m_flush > 0) || !m_ov || bus.out_ready;
    check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
    acc = bus.in_valid && exp_ready;
    bt  = int'(bus.br_type);
    taken = (bt == 1 && bus.alu_zero) || (bt == 2 && !bus.alu_zero) ||
            (bt == 3 && bus.alu_sgn)  || (bt == 4 && !bus.alu_sgn) ||
            bt == 5 || bt == 6;
    m_rv = 1'b0;
    if (m_ov && bus.out_ready) m_ov = 1'b0;
    if (m_flush > 0) begin
      m_flush = m_flush - 1;
    end else if (acc) begin
      m_ov  = 1'b1;
      m_res = (bt == 5 || bt == 6) ? bus.pc + 32'd4 : bus.alu_c;
      m_rd  = bus.rd;
      m_wb  = bus.wb_en && bus.rd != 0 && !(bt >= 1 && bt <= 4);
      if (taken) begin
        m_rv    = 1'b1;
        m_rpc   = (bt == 6) ? (bus.alu_c & 32'hFFFF_FFFE) : bus.pc + bus.imm;
        m_flush = FLUSH;
      end
    end
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    compare_outputs();
    check("reset redir_pc", bus.redir_pc, 32'h0);
    check("reset out_valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken: redirect, two dropped inputs, third passes.
    set_in(1, 3'b001, 32'h100, 32'h20, 32'h0, 1, 0, 5, 1);
    tick();
    check("beq redir_valid", {31'b0, bus.redir_valid}, 32'h1);
    check("beq redir_pc", bus.redir_pc, 32'h120);
    check("beq out_wb_en", {31'b0, bus.out_wb_en}, 32'h0);
    set_in(1, 3'b000, 32'h104, 0, 32'h11, 0, 0, 7, 1);
    tick();
    check("drop1 out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("drop1 redir_valid", {31'b0, bus.redir_valid}, 32'h0);
    set_in(1, 3'b000, 32'h108, 0, 32'h22, 0, 0, 7, 1);
    tick();
    check("drop2 out_valid", {31'b0, bus.out_valid}, 32'h0);
    set_in(1, 3'b000, 32'h120, 0, 32'h33, 0, 0, 7, 1);
    tick();
    check("pass3 out_valid", {31'b0, bus.out_valid}, 32'h1);
    check("pass3 out_res", bus.out_res, 32'h33);

    // BNE with zero=1: not taken.
    set_in(1, 3'b010, 32'h200, 32'h40, 32'h0, 1, 0, 2, 1);
    tick();
    check("bne redir_valid", {31'b0, bus.redir_valid}, 32'h0);
    check("bne out_valid", {31'b0, bus.out_valid}, 32'h1);
    check("bne in_ready", {31'b0, bus.in_ready}, 32'h1);

    // JALR: cleared LSB target, link value pc+4.
    set_in(1, 3'b110, 32'h40, 32'h0, 32'h2003, 0, 0, 1, 1);
    tick();
    check("jalr redir_pc", bus.redir_pc, 32'h2002);
    check("jalr out_res", bus.out_res, 32'h44);
    check("jalr out_wb_en", {31'b0, bus.out_wb_en}, 32'h1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (FLUSH) tick();

    // Stall: payload held while out_ready is low.
    set_in(1, 3'b000, 32'h300, 0, 32'h5, 0, 0, 3, 1);
    tick();
    check("add out_res", bus.out_res, 32'h5);
    bus.out_ready = 1'b0;
    set_in(1, 3'b000, 32'h304, 0, 32'h9, 0, 0, 4, 1);
    repeat (3) begin
      tick();
      check("stall out_res", bus.out_res, 32'h5);
      check("stall in_ready", {31'b0, bus.in_ready}, 32'h0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("unstall out_res", bus.out_res, 32'h9);

    // BLT taken with target wrap-around.
    set_in(1, 3'b011, 32'hFFFF_FFF0, 32'h20, 32'h8000_0000, 0, 1, 0, 0);
    tick();
    check("blt redir_pc", bus.redir_pc, 32'h0000_0010);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (FLUSH) tick();

    // Reset while flushing with one flush cycle left.
    set_in(1, 3'b001, 32'h300, 32'h8, 32'h0, 1, 0, 6, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    check("midflush reset redir_pc", bus.redir_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 3'b000, 32'h500, 0, 32'h77, 0, 0, 9, 1);
    tick();
    check("post-reset out_valid", {31'b0, bus.out_valid}, 32'h1);
    check("post-reset out_res", bus.out_res, 32'h77);

    // Randomized traffic against the model.
    repeat (3000) begin
      set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
             $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
